// File: rtl/affine2_pkg.sv
// Shared types and constants for the affine2 accumulate / requantize stage.
//  ACT_W, PSUM_W, NINV_W : activation, partial-sum and inverted-count widths
//  ACT_MAX, ACT_MIN      : signed activation range
//  psum_t, act_t         : signed partial sum and activation
//  act_res_t             : registered output payload (activation + saturation flag)
//  acc_state_e           : handshake view of the accumulator (ACCUM / FINAL)
package affine2_pkg;

  localparam int unsigned ACT_W  = 4;
  localparam int unsigned PSUM_W = 9;
  localparam int unsigned NINV_W = 6;
  localparam int          ACT_MAX = 7;
  localparam int          ACT_MIN = -8;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [ACT_W-1:0]  act_t;

  typedef struct packed {
    act_t data;
    logic ovf;
  } act_res_t;

  // ST_FINAL means the next accepted beat completes the current neuron.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FINAL = 1'b1
  } acc_state_e;

endpackage

// File: rtl/affine2_acc_if.sv
// Stream bundle between the first-stage adder, the accumulator and the next layer.
//  in_valid/in_ready/in_data/in_ninv : partial-sum beat stream into the accumulator
//  out_valid/out_ready/out_data/out_ovf : activation stream out of the accumulator
//  slave  : accumulator view (consumes beats, produces activations)
//  master : environment view (produces beats, consumes activations)
interface affine2_acc_if;
  import affine2_pkg::*;

  logic              in_valid;
  logic              in_ready;
  psum_t             in_data;
  logic [NINV_W-1:0] in_ninv;
  logic              out_valid;
  logic              out_ready;
  act_t              out_data;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_data, in_ninv, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, in_ninv, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/affine2_requant.sv
// Combinational requantizer: round-half-up, arithmetic right shift by SHIFT,
// saturate to the signed activation range.
//  acc_i : signed accumulated pre-activation (ACC_W bits)
//  act_o : signed activation
//  ovf_o : high when act_o was clamped
module affine2_requant
  import affine2_pkg::*;
#(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned SHIFT = 3
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output act_t                    act_o,
  output logic                    ovf_o
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int unsigned RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF  = RW'(1 << (SHIFT - 1));
  localparam logic signed [RW-1:0] R_MAX = RW'(ACT_MAX);
  localparam logic signed [RW-1:0] R_MIN = RW'(ACT_MIN);

  logic signed [RW-1:0] acc_ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] shr;

  // Round, shift, clamp.
  always_comb begin
    acc_ext = RW'(acc_i);
    rnd     = acc_ext + HALF;
    shr     = rnd >>> SHIFT;
    act_o   = shr[ACT_W-1:0];
    ovf_o   = 1'b0;
    if (shr > R_MAX) begin
      act_o = ACT_W'(ACT_MAX);
      ovf_o = 1'b1;
    end else if (shr < R_MIN) begin
      act_o = ACT_W'(ACT_MIN);
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/affine2_acc.sv
// Accumulates NBEATS one's-complement-corrected partial sums per neuron, then
// requantizes to a 4-bit signed activation held in an output register.
//  clk    : clock, all state on rising edge
//  rst_n  : asynchronous active-low reset
//  acc_if : slave side of the beat / activation stream bundle
//           (in_ready is combinational from out_ready; other outputs registered)
module affine2_acc
  import affine2_pkg::*;
#(
  parameter int unsigned NBEATS = 4,
  parameter int unsigned SHIFT  = 3,
  parameter int unsigned ACC_W  = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  affine2_acc_if.slave  acc_if
);

  localparam int unsigned CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(NBEATS - 2);
  localparam acc_state_e ST_START = (NBEATS == 1) ? ST_FINAL : ST_ACCUM;

  acc_state_e              state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  act_res_t                res_q, res_d;
  logic                    out_valid_q, out_valid_d;

  logic                    in_ready_c;
  logic                    accept_c;
  logic                    final_c;
  logic signed [ACC_W-1:0] psum_ext;
  logic signed [ACC_W-1:0] ninv_ext;
  logic signed [ACC_W-1:0] acc_sum_c;
  act_t                    act_c;
  logic                    ovf_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: advance to FINAL on the beat before last, back to start on the last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (accept_c && (beat_cnt_q == PRE_LAST)) state_d = ST_FINAL;
      ST_FINAL: if (accept_c) state_d = ST_START;
      default:  state_d = ST_START;
    endcase
  end

  // Handshake outputs: only the final beat stalls behind a held activation.
  always_comb begin
    in_ready_c = 1'b1;
    if ((state_q == ST_FINAL) && out_valid_q && !acc_if.out_ready) begin
      in_ready_c = 1'b0;
    end
    accept_c = acc_if.in_valid && in_ready_c;
    final_c  = accept_c && (state_q == ST_FINAL);
  end

  // +1 per inverted input turns the adder's ~x terms into -x.
  always_comb begin
    psum_ext  = ACC_W'(acc_if.in_data);
    ninv_ext  = ACC_W'(acc_if.in_ninv);
    acc_sum_c = acc_q + psum_ext + ninv_ext;
  end

  affine2_requant #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc_i (acc_sum_c),
    .act_o (act_c),
    .ovf_o (ovf_c)
  );

  // Datapath next-state; a load on the final beat overrides the output pop.
  always_comb begin
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && acc_if.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (final_c) begin
      acc_d       = '0;
      beat_cnt_d  = '0;
      res_d.data  = act_c;
      res_d.ovf   = ovf_c;
      out_valid_d = 1'b1;
    end else if (accept_c) begin
      acc_d      = acc_sum_c;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_if.in_ready  = in_ready_c;
  assign acc_if.out_valid = out_valid_q;
  assign acc_if.out_data  = res_q.data;
  assign acc_if.out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_affine2_acc.sv
// Scoreboard bench for affine2_acc (NBEATS=4, SHIFT=3): the driver pushes the
// expected activation when a neuron's last beat is accepted; a monitor pops and
// compares whenever an activation is presented.
module tb_affine2_acc;
  import affine2_pkg::*;

  localparam int NB = 4;

  typedef struct {
    int data;
    bit ovf;
    int edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  affine2_acc_if bus ();

  affine2_acc #(
    .NBEATS (4),
    .SHIFT  (3),
    .ACC_W  (12)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc_if (bus)
  );

  exp_t q[$];
  int   total_n = 0;
  int   bad_n   = 0;
  int   cyc     = 0;
  int   m_tot   = 0;
  int   m_nb    = 0;
  bit   rnd_ordy = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rnd_ordy) bus.out_ready = 1'($urandom_range(0, 1));

  always @(posedge clk)
    if (rst_n && bus.in_valid && bus.in_ready)
      assert (bus.in_ninv <= 6'd32) else $error("illegal in_ninv %0d", bus.in_ninv);

  function automatic void check(string name, int act, int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: exact rational rounding of total/8 (half up), then clamp.
  function automatic exp_t model_result(int tot, int edge_n);
    exp_t e;
    int   s;
    int   r;
    s = tot + 4;
    if (s >= 0) r = s / 8;
    else        r = -((-s + 7) / 8);
    e.edge_n = edge_n;
    e.ovf    = 1'b0;
    if (r > 7)       begin r = 7;  e.ovf = 1'b1; end
    else if (r < -8) begin r = -8; e.ovf = 1'b1; end
    e.data = r;
    return e;
  endfunction

  task automatic send_beat(int d, int n);
    bit acc;
    int e;
    int waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = psum_t'(d);
    bus.in_ninv  = 6'(n);
    forever begin
      #1;
      acc = bus.in_ready;
      e   = cyc + 1;
      @(posedge clk);
      if (acc) break;
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    if (acc) begin
      m_tot += d + n;
      m_nb++;
      if (m_nb == NB) begin
        q.push_back(model_result(m_tot, e));
        m_tot = 0;
        m_nb  = 0;
      end
    end
  endtask

  task automatic send_neuron(int d0, int d1, int d2, int d3, int n);
    send_beat(d0, n);
    send_beat(d1, n);
    send_beat(d2, n);
    send_beat(d3, n);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain", q.size(), 0);
  endtask

  // Monitor: compare every presented activation; latency checked when an item first appears.
  initial begin
    bit pv;
    bit px;
    pv = 1'b0;
    px = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv = 1'b0;
        px = 1'b0;
        continue;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          if (!pv || px) check("out_latency_edge", cyc, q[0].edge_n);
          check("out_data", int'(bus.out_data), q[0].data);
          check("out_ovf", int'(bus.out_ovf), int'(q[0].ovf));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      pv = bus.out_valid;
      px = bus.out_valid && bus.out_ready;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ninv   = '0;
    bus.out_ready = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_ovf", int'(bus.out_ovf), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic accumulate, inversion correction, saturation both ways
    send_neuron(10, 10, 10, 10, 0);
    send_neuron(-5, -5, -5, -5, 5);
    send_neuron(240, 240, 240, 240, 0);
    send_neuron(-256, -256, -256, -256, 0);
    // Rounding: totals 12, 11, -13, and one with inversion counts
    send_neuron(3, 3, 3, 3, 0);
    send_neuron(2, 3, 3, 3, 0);
    send_neuron(-4, -3, -3, -3, 0);
    send_neuron(-30, -20, -10, 0, 32);
    drain();

    // Backpressure: A held, B's first three beats flow, fourth stalls
    bus.out_ready = 1'b0;
    send_neuron(20, 20, 20, 20, 0);
    send_beat(-9, 1);
    send_beat(-9, 1);
    send_beat(-9, 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = psum_t'(-9);
    bus.in_ninv  = 6'(1);
    #1;
    check("stall_in_ready", int'(bus.in_ready), 0);
    check("held_out_valid", int'(bus.out_valid), 1);
    fork
      send_beat(-9, 1);
      begin
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-neuron with an output held
    bus.out_ready = 1'b0;
    send_neuron(50, 50, 50, 50, 0);
    send_beat(100, 0);
    send_beat(100, 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    m_tot = 0;
    m_nb  = 0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_data", int'(bus.out_data), 0);
    check("midrst_out_ovf", int'(bus.out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_neuron(8, 8, 8, 8, 0);
    drain();

    // Random beats, gaps and backpressure
    rnd_ordy = 1'b1;
    for (int i = 0; i < 160; i++) begin
      int d;
      int n;
      d = int'($urandom_range(0, 511)) - 256;
      n = int'($urandom_range(0, 32));
      send_beat(d, n);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rnd_ordy = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();
    check("model_beat_phase", m_nb, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
